aes_decipher_ctrl: RTL

- Sequencer for the iterative AES inverse-cipher datapath.
- Accepts one 128-bit ciphertext block per valid/ready handshake and presents it to the datapath.
- Drives the datapath round index through every decryption round, one round per clock.
- Captures the plaintext and returns it over a valid/ready output handshake; it sits between the block-level stream interface and the datapath/key-expansion pair.

---
 rtl/aes_decipher_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl
//   Sequencer for the iterative AES inverse-cipher datapath. One ciphertext
//   block is taken per in_valid/in_ready handshake, held on dp_in, and the
//   datapath is stepped through rounds NR..2*NR, one round per clock. The
//   result is captured from dp_out on the last round and returned over the
//   out_valid/out_ready handshake.
//
// Parameter
//   x         key-size selector: 0 = AES-128, 1 = AES-192, 2 = AES-256
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  ciphertext block offered
//   in_ready  controller accepts a block this cycle (combinational)
//   in_data   ciphertext
//   key_valid expanded key schedule stable and usable
//   dp_in     ciphertext held for the datapath
//   dp_round  round index to the datapath (parks at 2*NR+1 when idle)
//   dp_out    datapath result
//   out_valid plaintext available
//   out_ready consumer accepts plaintext
//   out_data  plaintext
//   busy      high while a block is in RUN or DONE
//   key_err   sticky: key_valid fell while busy
//   blk_cnt   completed output handshakes, saturating
module aes_decipher_ctrl #(
  parameter int x = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         key_valid,
  output logic [0:127] dp_in,
  output logic [4:0]   dp_round,
  input  logic [0:127] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy,
  output logic         key_err,
  output logic [15:0]  blk_cnt
);

  localparam int NR = 10 + 2 * x;
  localparam logic [4:0] RND_FIRST = 5'(NR);
  localparam logic [4:0] RND_LAST  = 5'(2 * NR);
  localparam logic [4:0] RND_PARK  = 5'(2 * NR + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic accept;
  logic out_hs;
  logic last_rnd;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Handshake and round decode
  always_comb begin
    in_ready = key_valid && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept   = in_valid && in_ready;
    out_hs   = out_valid && out_ready;
    last_rnd = (state_q == RUN) && (dp_round == RND_LAST);
    busy     = (state_q != IDLE);
  end

  // Next-state: a DONE state that hands off and accepts at the same edge
  // goes straight back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_rnd) state_d = DONE;
      DONE: begin
        if (accept)      state_d = RUN;
        else if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Block capture and round sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_in    <= '0;
      dp_round <= RND_PARK;
    end else begin
      if (accept) dp_in <= in_data;
      if (accept)        dp_round <= RND_FIRST;
      else if (last_rnd) dp_round <= RND_PARK;
      else if (state_q == RUN) dp_round <= dp_round + 5'd1;
    end
  end

  // Result capture, output handshake and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      key_err   <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (last_rnd) out_data <= dp_out;
      if (last_rnd)    out_valid <= 1'b1;
      else if (out_hs) out_valid <= 1'b0;
      if (busy && !key_valid) key_err <= 1'b1;
      if (out_hs) blk_cnt <= sat_inc16(blk_cnt);
    end
  end

endmodule
